// File: rtl/bpu_update_sched.sv
// Update-port sequencer for the branch predictor: buffers branch resolutions in a FIFO,
// drains one per cycle, and runs a BTB/PHT invalidate sweep after reset or on request.
module bpu_update_sched #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INDEX_WIDTH = 6,
   parameter int QUEUE_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   resolve_valid,
   input  logic                   resolve_is_branch,
   input  logic [ADDR_WIDTH-1:0]  resolve_pc,
   input  logic [ADDR_WIDTH-1:0]  resolve_target,
   input  logic                   resolve_taken,
   output logic                   resolve_ready,
   input  logic                   inv_req,
   output logic                   upd_valid,
   output logic [ADDR_WIDTH-1:0]  upd_pc,
   output logic [ADDR_WIDTH-1:0]  upd_target,
   output logic                   upd_taken,
   output logic                   upd_clear,
   output logic [INDEX_WIDTH-1:0] upd_index,
   output logic                   pred_enable
);

   localparam int PTR_W = $clog2(QUEUE_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [ADDR_WIDTH-1:0] target;
      logic                  taken;
   } entry_t;

   state_t                 state, state_nx;
   logic [INDEX_WIDTH-1:0] idx, idx_nx;

   entry_t                 mem [QUEUE_DEPTH];
   logic [PTR_W-1:0]       rd_ptr, wr_ptr;
   logic [CNT_W-1:0]       count;
   logic                   full, empty, push, pop;

   assign full  = (count == CNT_W'(QUEUE_DEPTH));
   assign empty = (count == '0);
   // Acceptance depends on occupancy only: a same-cycle pop never frees a slot early.
   assign push  = resolve_valid & resolve_is_branch & ~full & ~rst;
   assign pop   = (state == ST_RUN) & ~empty & ~rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_INIT;
         idx   <= '0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      if (inv_req) begin
         state_nx = ST_INIT;
         idx_nx   = '0;
      end else if (state == ST_INIT) begin
         idx_nx = idx + INDEX_WIDTH'(1);
         if (idx == '1)
            state_nx = ST_RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < QUEUE_DEPTH; i++)
            mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{pc: resolve_pc, target: resolve_target, taken: resolve_taken};
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      resolve_ready = 1'b0;
      upd_valid     = 1'b0;
      upd_clear     = 1'b0;
      upd_index     = '0;
      pred_enable   = 1'b0;
      upd_pc        = '0;
      upd_target    = '0;
      upd_taken     = 1'b0;
      if (!rst) begin
         resolve_ready = ~full;
         upd_pc        = mem[rd_ptr].pc;
         upd_target    = mem[rd_ptr].target;
         upd_taken     = mem[rd_ptr].taken;
         case (state)
            ST_INIT: begin
               upd_clear = 1'b1;
               upd_index = idx;
            end
            ST_RUN: begin
               pred_enable = 1'b1;
               upd_valid   = ~empty;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bpu_update_sched.sv
// Self-checking bench for bpu_update_sched: directed table, hand-written corner sequences
// and randomized traffic, all checked against a queue-based reference model.
module tb_bpu_update_sched;

   localparam int AW    = 32;
   localparam int IW    = 6;
   localparam int QD    = 4;
   localparam int SWEEP = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          resolve_valid, resolve_is_branch, resolve_taken, inv_req;
   logic [AW-1:0] resolve_pc, resolve_target;
   logic          resolve_ready, upd_valid, upd_taken, upd_clear, pred_enable;
   logic [AW-1:0] upd_pc, upd_target;
   logic [IW-1:0] upd_index;

   always #5 clk = ~clk;

   bpu_update_sched #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW), .QUEUE_DEPTH(QD)) dut (
      .clk(clk), .rst(rst),
      .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
      .resolve_pc(resolve_pc), .resolve_target(resolve_target),
      .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
      .inv_req(inv_req),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
      .upd_taken(upd_taken), .upd_clear(upd_clear), .upd_index(upd_index),
      .pred_enable(pred_enable)
   );

   typedef struct {
      logic [AW-1:0] pc;
      logic [AW-1:0] tgt;
      logic          tk;
   } ent_t;

   typedef struct {
      logic          v, br, inv;
      logic [AW-1:0] pc, tgt;
      logic          tk;
      logic          e_ready, e_valid, e_clear, e_pred;
      int            e_index;
      logic [AW-1:0] e_pc, e_tgt;
      logic          e_tk;
   } vec_t;

   ent_t mq[$];
   bit   m_init  = 1'b1;
   int   m_sweep = 0;
   int   checks  = 0;
   int   errors  = 0;
   int   cyc     = 0;
   int   first_pop_cyc = -1;

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic idle_in();
      resolve_valid = 1'b0; resolve_is_branch = 1'b0; inv_req = 1'b0;
      resolve_pc = '0; resolve_target = '0; resolve_taken = 1'b0;
   endtask

   // Called at a negedge: compare against the model, then advance model across the edge.
   task automatic model_cycle();
      bit   e_ready, e_valid, e_clear, e_pred, do_push, do_pop, s_inv, s_rst;
      int   e_idx;
      ent_t in_e;
      e_ready = 0; e_valid = 0; e_clear = 0; e_pred = 0; e_idx = 0;
      if (!rst) begin
         e_ready = (mq.size() < QD);
         if (m_init) begin
            e_clear = 1; e_idx = m_sweep;
         end else begin
            e_pred = 1; e_valid = (mq.size() > 0);
         end
      end
      chk("ready", resolve_ready, e_ready);
      chk("upd_valid", upd_valid, e_valid);
      chk("upd_clear", upd_clear, e_clear);
      chk("pred_enable", pred_enable, e_pred);
      chk("valid_and_clear", upd_valid & upd_clear, 0);
      if (rst || e_clear) chk("upd_index", upd_index, e_idx);
      if (e_valid) begin
         chk("upd_pc", upd_pc, mq[0].pc);
         chk("upd_target", upd_target, mq[0].tgt);
         chk("upd_taken", upd_taken, mq[0].tk);
      end
      if (upd_valid && first_pop_cyc < 0) first_pop_cyc = cyc;
      do_push = !rst && resolve_valid && resolve_is_branch && e_ready;
      do_pop  = e_valid;
      s_inv   = inv_req;
      s_rst   = rst;
      in_e    = '{pc: resolve_pc, tgt: resolve_target, tk: resolve_taken};
      @(posedge clk);
      cyc++;
      if (s_rst) begin
         mq.delete(); m_init = 1; m_sweep = 0;
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (do_push) mq.push_back(in_e);
         if (s_inv) begin
            m_init = 1; m_sweep = 0;
         end else if (m_init) begin
            if (m_sweep == SWEEP - 1) m_init = 0;
            else m_sweep++;
         end
      end
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      model_cycle();
   endtask

   // Source holds the branch until the DUT accepts it; returns the acceptance cycle.
   task automatic push_hold(input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                            input logic tk, output int acc);
      acc = -1;
      resolve_valid = 1'b1; resolve_is_branch = 1'b1;
      resolve_pc = pc; resolve_target = tgt; resolve_taken = tk;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (resolve_ready) acc = cyc;
         model_cycle();
         if (acc >= 0) break;
      end
      if (acc < 0) begin
         checks++; errors++;
         $display("FAIL push_timeout: got no acceptance, expected acceptance within 200 cycles");
      end
      resolve_valid = 1'b0; resolve_is_branch = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[12];
      int   acc[5];
      int   n;
      logic [AW-1:0] a_pc, b_pc;

      a_pc = 32'h1c00_0100;
      b_pc = 32'h1c00_0200;
      //          v  br inv pc            tgt           tk  rdy val clr prd idx e_pc          e_tgt         e_tk
      tv[0]  = '{1, 1, 0, 32'h1c000010, 32'h1c000040, 1,  1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[1]  = '{0, 0, 0, '0,           '0,           0,  1,  1,  0,  1,  0,  32'h1c000010, 32'h1c000040, 1};
      tv[2]  = '{0, 0, 0, '0,           '0,           0,  1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[3]  = '{1, 0, 0, 32'h2000,     32'h3000,     1,  1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[4]  = '{0, 0, 0, '0,           '0,           0,  1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[5]  = '{1, 1, 0, a_pc,         a_pc + 32'h40, 0, 1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[6]  = '{1, 1, 0, b_pc,         b_pc + 32'h40, 1, 1,  1,  0,  1,  0,  a_pc,         a_pc + 32'h40, 0};
      tv[7]  = '{1, 0, 0, 32'h5555,     32'h6666,     1,  1,  1,  0,  1,  0,  b_pc,         b_pc + 32'h40, 1};
      tv[8]  = '{0, 0, 0, '0,           '0,           0,  1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[9]  = '{0, 0, 1, '0,           '0,           0,  1,  0,  0,  1,  0,  '0,           '0,           0};
      tv[10] = '{0, 0, 0, '0,           '0,           0,  1,  0,  1,  0,  0,  '0,           '0,           0};
      tv[11] = '{0, 0, 0, '0,           '0,           0,  1,  0,  1,  0,  1,  '0,           '0,           0};

      idle_in();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;

      // Post-reset sweep: indices 0..63, then predictions enabled on cycle 65.
      for (int i = 0; i < SWEEP; i++) begin
         @(negedge clk);
         chk("t1_sweep_idx", upd_index, i);
         chk("t1_sweep_clear", upd_clear, 1);
         model_cycle();
      end
      @(negedge clk);
      chk("t1_pred_cycle65", pred_enable, 1);
      model_cycle();

      for (int i = 0; i < 12; i++) begin
         resolve_valid = tv[i].v; resolve_is_branch = tv[i].br; inv_req = tv[i].inv;
         resolve_pc = tv[i].pc; resolve_target = tv[i].tgt; resolve_taken = tv[i].tk;
         @(negedge clk);
         chk($sformatf("tv%0d_ready", i), resolve_ready, tv[i].e_ready);
         chk($sformatf("tv%0d_valid", i), upd_valid, tv[i].e_valid);
         chk($sformatf("tv%0d_clear", i), upd_clear, tv[i].e_clear);
         chk($sformatf("tv%0d_pred", i), pred_enable, tv[i].e_pred);
         if (tv[i].e_clear) chk($sformatf("tv%0d_index", i), upd_index, tv[i].e_index);
         if (tv[i].e_valid) begin
            chk($sformatf("tv%0d_pc", i), upd_pc, tv[i].e_pc);
            chk($sformatf("tv%0d_tgt", i), upd_target, tv[i].e_tgt);
            chk($sformatf("tv%0d_tk", i), upd_taken, tv[i].e_tk);
         end
         model_cycle();
      end
      idle_in();

      // Five pushes during INIT: four fill the FIFO, the fifth lands the cycle after the first pop.
      first_pop_cyc = -1;
      for (int k = 0; k < 5; k++)
         push_hold(32'h1c00_1000 + 32'(k * 4), 32'h1c00_1800 + 32'(k * 4), 1'(k), acc[k]);
      chk("t3_fill_consecutive", acc[3] - acc[0], 3);
      chk("t3_fifth_held", (acc[4] > acc[3] + 1), 1);
      chk("t3_fifth_after_pop", acc[4], first_pop_cyc + 1);
      repeat (8) tick();

      // Invalidate restart mid-sweep with queued entries.
      inv_req = 1'b1; tick(); inv_req = 1'b0;
      push_hold(32'h1c00_3000, 32'h1c00_3100, 1'b1, acc[0]);
      push_hold(32'h1c00_3004, 32'h1c00_3104, 1'b0, acc[1]);
      n = 0;
      while (m_sweep != 30 && n < 100) begin tick(); n++; end
      inv_req = 1'b1; tick(); inv_req = 1'b0;
      @(negedge clk);
      chk("t5_restart_idx", upd_index, 0);
      n = 0;
      while (upd_clear && n < 200) begin
         n++;
         model_cycle();
         @(negedge clk);
      end
      chk("t5_sweep_len", n, SWEEP);
      chk("t5_survivor_valid", upd_valid, 1);
      chk("t5_survivor_pc", upd_pc, 32'h1c00_3000);
      model_cycle();
      repeat (4) tick();

      // Full FIFO in RUN under continuous offer: four laps of the pointers, then reset mid-drain.
      inv_req = 1'b1; tick(); inv_req = 1'b0;
      for (int k = 0; k < 16; k++)
         push_hold(32'h1c00_2000 + 32'(k * 4), 32'h1c00_2100 + 32'(k * 4), 1'(k), acc[0]);
      chk("t6_queue_nonempty", (mq.size() > 0), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_idx0", upd_index, 0);
      chk("t6_rst_clear", upd_clear, 1);
      model_cycle();
      repeat (SWEEP + 3) tick();
      chk("t6_queue_lost", mq.size(), 0);

      // Randomized traffic with interleaved non-branches, rare invalidates and resets.
      for (int i = 0; i < 3000; i++) begin
         resolve_valid     = 1'($urandom_range(0, 1));
         resolve_is_branch = ($urandom_range(0, 3) != 0);
         resolve_pc        = $urandom;
         resolve_target    = $urandom;
         resolve_taken     = 1'($urandom_range(0, 1));
         inv_req           = ($urandom_range(0, 199) == 0);
         rst               = ($urandom_range(0, 799) == 0);
         tick();
      end
      idle_in();
      rst = 1'b0;
      repeat (4) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
